// File: rtl/wb_cmd_initiator.sv
// Wishbone classic single-transfer initiator driven by a valid/ready command stream.
// Optional watchdog on unacknowledged cycles: define WBM_TIMEOUT_EN.
module wb_cmd_initiator #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy_o
);

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("wb_cmd_initiator: TIMEOUT must be 1..65535");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;

    logic        r_cmd_ready;
    logic        r_cyc;
    logic        r_we;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic [3:0]  r_sel;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_dat;

    logic        w_cyc_nx;
    logic        w_we_nx;
    logic [31:0] w_adr_nx;
    logic [31:0] w_dat_nx;
    logic [3:0]  w_sel_nx;
    logic        w_rsp_valid_nx;
    logic [31:0] w_rsp_dat_nx;
    logic        w_cmd_hs;

`ifdef WBM_TIMEOUT_EN
    localparam logic [15:0] LP_TMO_LAST = 16'(TIMEOUT - 1);

    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nx;
    logic        r_rsp_err;
    logic        w_rsp_err_nx;
`endif

    assign w_cmd_hs = cmd_valid_i & r_cmd_ready;

    always_comb begin
        w_state_nx     = r_state;
        w_cyc_nx       = r_cyc;
        w_we_nx        = r_we;
        w_adr_nx       = r_adr;
        w_dat_nx       = r_dat;
        w_sel_nx       = r_sel;
        w_rsp_valid_nx = r_rsp_valid;
        w_rsp_dat_nx   = r_rsp_dat;
`ifdef WBM_TIMEOUT_EN
        w_cnt_nx       = r_cnt;
        w_rsp_err_nx   = r_rsp_err;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (w_cmd_hs) begin
                    w_we_nx    = cmd_we_i;
                    w_adr_nx   = cmd_adr_i;
                    w_dat_nx   = cmd_dat_i;
                    w_sel_nx   = cmd_sel_i;
                    w_cyc_nx   = 1'b1;
                    w_state_nx = S_BUS;
`ifdef WBM_TIMEOUT_EN
                    w_cnt_nx   = 16'd0;
`endif
                end
            end
            S_BUS: begin
                if (wbm_ack_i) begin
                    w_rsp_dat_nx   = r_we ? 32'd0 : wbm_dat_i;
                    w_rsp_valid_nx = 1'b1;
                    w_cyc_nx       = 1'b0;
                    w_state_nx     = S_RESP;
`ifdef WBM_TIMEOUT_EN
                    w_rsp_err_nx   = 1'b0;
                end else if (r_cnt == LP_TMO_LAST) begin
                    // Ack on the expiry edge takes the branch above instead.
                    w_rsp_dat_nx   = 32'd0;
                    w_rsp_err_nx   = 1'b1;
                    w_rsp_valid_nx = 1'b1;
                    w_cyc_nx       = 1'b0;
                    w_state_nx     = S_RESP;
                end else begin
                    w_cnt_nx       = r_cnt + 16'd1;
`endif
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    w_rsp_valid_nx = 1'b0;
                    w_state_nx     = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cyc_nx   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= 32'd0;
            r_dat       <= 32'd0;
            r_sel       <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= 32'd0;
        end else begin
            r_state     <= w_state_nx;
            r_cmd_ready <= (w_state_nx == S_IDLE);
            r_cyc       <= w_cyc_nx;
            r_we        <= w_we_nx;
            r_adr       <= w_adr_nx;
            r_dat       <= w_dat_nx;
            r_sel       <= w_sel_nx;
            r_rsp_valid <= w_rsp_valid_nx;
            r_rsp_dat   <= w_rsp_dat_nx;
        end
    end

`ifdef WBM_TIMEOUT_EN
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_cnt     <= 16'd0;
            r_rsp_err <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nx;
            r_rsp_err <= w_rsp_err_nx;
        end
    end

    assign rsp_err_o = r_rsp_err;
`else
    assign rsp_err_o = 1'b0;
`endif

    assign cmd_ready_o = r_cmd_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_dat_o   = r_rsp_dat;
    assign wbm_cyc_o   = r_cyc;
    assign wbm_stb_o   = r_cyc;
    assign wbm_we_o    = r_we;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_dat;
    assign wbm_sel_o   = r_sel;
    assign busy_o      = (r_state != S_IDLE);

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Scoreboard bench for wb_cmd_initiator: directed commands, modelled slave,
// response monitor popping expected results.
module tb_wb_cmd_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        cyc, stb, we;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
    logic [31:0] s_dat;
    logic        s_ack, stray_ack, ack;
    logic        busy;

    always #5 clk = ~clk;

    assign ack = s_ack | stray_ack;

    wb_cmd_initiator #(.TIMEOUT(4)) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .cmd_sel_i   (cmd_sel),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .wbm_cyc_o   (cyc),
        .wbm_stb_o   (stb),
        .wbm_we_o    (we),
        .wbm_adr_o   (adr),
        .wbm_dat_o   (wdat),
        .wbm_sel_o   (sel),
        .wbm_dat_i   (s_dat),
        .wbm_ack_i   (ack),
        .busy_o      (busy)
    );

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;
    int rsp_edge = 0;
    int n_rsp = 0;
    int n_push = 0;

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic e);
        rsp_t r;
        r.dat = d;
        r.err = e;
        exp_q.push_back(r);
        n_push++;
    endtask

    always @(posedge clk) cyc_n++;

    // Response monitor: pops one expected entry per response handshake.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            rsp_edge = cyc_n + 1;
            n_rsp++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp got=%h exp=none", rsp_dat);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_dat", rsp_dat, e.dat);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            end
        end
    end

    // Slave model: acks on stb cycle number ack_after (0 = never).
    int          ack_after = 1;
    int          s_cnt = 0;
    int          stb_len = 0;
    logic [31:0] rd_data = 32'd0;
    logic [31:0] cap_adr, cap_dat;
    logic [3:0]  cap_sel;
    logic        cap_we;
    logic        bus_ok = 1'b1;

    initial begin
        s_ack = 1'b0;
        s_dat = 32'hFFFF_FFFF;
    end

    always @(negedge clk) begin
        if (stb !== cyc) bus_ok = 1'b0;
        if (cyc && stb) begin
            if (s_cnt == 0) begin
                cap_adr = adr;
                cap_dat = wdat;
                cap_sel = sel;
                cap_we  = we;
            end else if (adr !== cap_adr || wdat !== cap_dat ||
                         sel !== cap_sel || we !== cap_we) begin
                bus_ok = 1'b0;
            end
            s_cnt++;
            s_ack = (ack_after != 0) && (s_cnt == ack_after);
            s_dat = s_ack ? rd_data : 32'hFFFF_FFFF;
        end else begin
            if (s_cnt != 0) stb_len = s_cnt;
            s_cnt = 0;
            s_ack = 1'b0;
            s_dat = 32'hFFFF_FFFF;
        end
    end

    task automatic send_cmd(input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s,
                            output int hs_edge);
        logic ok;
        ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_we = w;
        cmd_adr = a;
        cmd_dat = d;
        cmd_sel = s;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        hs_edge = cyc_n;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL cmd_accept got=timeout exp=handshake");
        end
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = !busy && !rsp_valid;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL wait_idle got=busy exp=idle");
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    int          e0, e1;
    logic [31:0] held;

    initial begin
        cmd_valid = 1'b0;
        cmd_we = 1'b0;
        cmd_adr = 32'd0;
        cmd_dat = 32'd0;
        cmd_sel = 4'd0;
        rsp_ready = 1'b1;
        stray_ack = 1'b0;

        #12;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_cyc", {31'd0, cyc}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Write, ack on the first stb cycle.
        ack_after = 1;
        push_exp(32'd0, 1'b0);
        send_cmd(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, e0);
        chk("wr_cyc", {31'd0, cyc}, 32'd1);
        chk("wr_stb", {31'd0, stb}, 32'd1);
        @(posedge clk);
        #1;
        chk("wr_rsp_lat", {31'd0, rsp_valid}, 32'd1);
        chk("wr_cyc_drop", {31'd0, cyc}, 32'd0);
        wait_idle();
        chk("wr_stb_len", stb_len, 32'd1);
        chk("wr_adr", cap_adr, 32'h3000_0004);
        chk("wr_dat", cap_dat, 32'hDEAD_BEEF);
        chk("wr_sel", {28'd0, cap_sel}, 32'hF);
        chk("wr_we", {31'd0, cap_we}, 32'd1);

        // Read with two wait states.
        ack_after = 3;
        rd_data = 32'h1234_5678;
        push_exp(32'h1234_5678, 1'b0);
        send_cmd(1'b0, 32'h3000_0000, 32'hCAFE_F00D, 4'hF, e0);
        wait_idle();
        chk("rd_stb_len", stb_len, 32'd3);
        chk("rd_adr", cap_adr, 32'h3000_0000);
        chk("rd_we", {31'd0, cap_we}, 32'd0);

        // Response back-pressure with a command waiting.
        rsp_ready = 1'b0;
        ack_after = 1;
        rd_data = 32'hA5A5_0001;
        push_exp(32'hA5A5_0001, 1'b0);
        push_exp(32'd0, 1'b0);
        send_cmd(1'b0, 32'h3000_0008, 32'd0, 4'hF, e0);
        @(posedge clk);
        #1;
        held = rsp_dat;
        chk("bp_first", held, 32'hA5A5_0001);
        fork
            send_cmd(1'b1, 32'h3000_000C, 32'h1122_3344, 4'h3, e1);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
                    chk("bp_dat", rsp_dat, held);
                    chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
                end
                @(posedge clk);
                #1;
                rsp_ready = 1'b1;
            end
        join
        chk("bp_cmd_edge", e1, rsp_edge + 1);
        wait_idle();
        chk("bp_sel", {28'd0, cap_sel}, 32'h3);
        chk("bp_we", {31'd0, cap_we}, 32'd1);

`ifdef WBM_TIMEOUT_EN
        // Watchdog expiry, then ack on the expiry cycle.
        ack_after = 0;
        rd_data = 32'hFFFF_0000;
        push_exp(32'd0, 1'b1);
        send_cmd(1'b0, 32'h3000_0020, 32'd0, 4'hF, e0);
        wait_idle();
        chk("wd_stb_len", stb_len, 32'd4);
        ack_after = 4;
        rd_data = 32'h0BAD_F00D;
        push_exp(32'h0BAD_F00D, 1'b0);
        send_cmd(1'b0, 32'h3000_0024, 32'd0, 4'hF, e0);
        wait_idle();
        chk("wd_ack_len", stb_len, 32'd4);
`endif

        // Reset in the middle of a bus cycle.
        ack_after = 0;
        send_cmd(1'b0, 32'h3000_0010, 32'd0, 4'hF, e0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cyc", {31'd0, cyc}, 32'd0);
        chk("mid_rst_stb", {31'd0, stb}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
        ack_after = 2;
        rd_data = 32'h5555_AAAA;
        push_exp(32'h5555_AAAA, 1'b0);
        send_cmd(1'b0, 32'h3000_0014, 32'd0, 4'hF, e0);
        wait_idle();
        chk("post_rst_len", stb_len, 32'd2);

        // Stray acks in IDLE and in RESP.
        stray_ack = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        stray_ack = 1'b0;
        chk("stray_idle_busy", {31'd0, busy}, 32'd0);
        chk("stray_idle_cyc", {31'd0, cyc}, 32'd0);
        chk("stray_idle_rsp", {31'd0, rsp_valid}, 32'd0);
        rsp_ready = 1'b0;
        ack_after = 1;
        rd_data = 32'h0F0F_1234;
        push_exp(32'h0F0F_1234, 1'b0);
        send_cmd(1'b0, 32'h3000_0018, 32'd0, 4'hF, e0);
        @(posedge clk);
        #1;
        stray_ack = 1'b1;
        @(posedge clk);
        #1;
        stray_ack = 1'b0;
        chk("stray_resp_busy", {31'd0, busy}, 32'd1);
        chk("stray_resp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("stray_resp_cyc", {31'd0, cyc}, 32'd0);
        chk("stray_resp_dat", rsp_dat, 32'h0F0F_1234);
        rsp_ready = 1'b1;
        wait_idle();

        chk("bus_stable", {31'd0, bus_ok}, 32'd1);
        chk("rsp_count", n_rsp, n_push);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
